// File: rtl/logic_engine_bridge.sv
// logic_engine_bridge: CPU request/ack to engine valid/ready bridge; define LOGIC_BRIDGE_TIMEOUT_EN for an abort-on-timeout counter.
module logic_engine_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        logic_req,
  input  logic [31:0] logic_addr,
  output logic        logic_ack,
  output logic [31:0] logic_data,
  output logic        eng_req_valid,
  input  logic        eng_req_ready,
  output logic [31:0] eng_req_addr,
  input  logic        eng_rsp_valid,
  input  logic [31:0] eng_rsp_data,
  output logic        eng_rsp_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] req_count
);
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_ISSUE   = 5'b00010,
    S_WAIT    = 5'b00100,
    S_ACK     = 5'b01000,
    S_RELEASE = 5'b10000
  } state_t;
  state_t      state_q;
  logic [31:0] addr_q, data_q, count_q;
  logic        rdy_q, terr_q, to_hit;
`ifdef LOGIC_BRIDGE_TIMEOUT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= (state_q == S_ISSUE || state_q == S_WAIT) ? cnt_q + 32'd1 : '0;
  // Fires on the cycle whose increment would make the count reach the limit.
  assign to_hit = (state_q == S_ISSUE || state_q == S_WAIT) && cnt_q == 32'(TIMEOUT_CYCLES - 1);
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        S_IDLE:
          if (logic_req) begin
            state_q <= S_ISSUE;
            addr_q  <= logic_addr;
            terr_q  <= 1'b0;
            rdy_q   <= 1'b0;
          end
        S_ISSUE:
          if (to_hit) begin
            state_q <= S_ACK;
            data_q  <= ERR_DATA;
            terr_q  <= 1'b1;
            count_q <= count_q + 32'd1;
            rdy_q   <= 1'b0;
          end else if (eng_req_ready) state_q <= S_WAIT;
          else rdy_q <= 1'b0;
        S_WAIT:
          // A response arriving together with the timeout still returns real data.
          if (eng_rsp_valid || to_hit) begin
            state_q <= S_ACK;
            data_q  <= eng_rsp_valid ? eng_rsp_data : ERR_DATA;
            terr_q  <= !eng_rsp_valid;
            count_q <= count_q + 32'd1;
            rdy_q   <= 1'b0;
          end
        S_ACK: state_q <= S_RELEASE;
        S_RELEASE: if (!logic_req) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  assign logic_ack     = state_q == S_ACK;
  assign logic_data    = data_q;
  assign eng_req_valid = state_q == S_ISSUE;
  assign eng_req_addr  = addr_q;
  assign eng_rsp_ready = rdy_q;
  assign busy          = state_q != S_IDLE;
  assign timeout_err   = terr_q;
  assign req_count     = count_q;
endmodule

// File: tb/tb_logic_engine_bridge.sv
// tb_logic_engine_bridge: directed self-checking bench for logic_engine_bridge.
module tb_logic_engine_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, erdy = 1'b0, rvld = 1'b0;
  logic [31:0] addr = '0, rdata = '0;
  logic        ack, vld, rrdy, busy, terr;
  logic [31:0] data, eaddr, cnt;
  int          n_cmp = 0, n_bad = 0;

  logic_engine_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .logic_req(req), .logic_addr(addr), .logic_ack(ack),
    .logic_data(data), .eng_req_valid(vld), .eng_req_ready(erdy), .eng_req_addr(eaddr),
    .eng_rsp_valid(rvld), .eng_rsp_data(rdata), .eng_rsp_ready(rrdy), .busy(busy),
    .timeout_err(terr), .req_count(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(); tick();
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %h want 0", ack); end
    n_cmp++; if (data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", data); end
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %h want 0", vld); end
    n_cmp++; if (eaddr !== 32'h0) begin n_bad++; $display("FAIL reset_eaddr got %h want 0", eaddr); end
    n_cmp++; if (rrdy !== 1'b0) begin n_bad++; $display("FAIL reset_rrdy got %h want 0", rrdy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %h want 0", busy); end
    n_cmp++; if (terr !== 1'b0) begin n_bad++; $display("FAIL reset_terr got %h want 0", terr); end
    n_cmp++; if (cnt !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got %h want 0", cnt); end
    rst = 1'b0;
    tick();
    n_cmp++; if (rrdy !== 1'b1) begin n_bad++; $display("FAIL reset_rrdy_rise got %h want 1", rrdy); end
  endtask

  task automatic test_normal;
    req = 1'b1; addr = 32'h40; erdy = 1'b1; rvld = 1'b0;
    tick();
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL normal_issue_vld got %h want 1", vld); end
    n_cmp++; if (eaddr !== 32'h40) begin n_bad++; $display("FAIL normal_eaddr got %h want 40", eaddr); end
    n_cmp++; if (rrdy !== 1'b0) begin n_bad++; $display("FAIL normal_issue_rrdy got %h want 0", rrdy); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL normal_busy got %h want 1", busy); end
    rvld = 1'b1; rdata = 32'hABCD1234;
    tick();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL normal_wait_vld got %h want 0", vld); end
    n_cmp++; if (rrdy !== 1'b1) begin n_bad++; $display("FAIL normal_wait_rrdy got %h want 1", rrdy); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL normal_early_ack got %h want 0", ack); end
    tick();
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL normal_ack got %h want 1", ack); end
    n_cmp++; if (data !== 32'hABCD1234) begin n_bad++; $display("FAIL normal_data got %h want abcd1234", data); end
    n_cmp++; if (cnt !== 32'd1) begin n_bad++; $display("FAIL normal_cnt got %h want 1", cnt); end
    n_cmp++; if (rrdy !== 1'b0) begin n_bad++; $display("FAIL normal_ack_rrdy got %h want 0", rrdy); end
    rvld = 1'b0; req = 1'b0;
    tick();
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL normal_ack_pulse got %h want 0", ack); end
    n_cmp++; if (data !== 32'hABCD1234) begin n_bad++; $display("FAIL normal_data_hold got %h want abcd1234", data); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL normal_idle_busy got %h want 0", busy); end
  endtask

  task automatic test_held;
    int hs = 0, acks = 0;
    req = 1'b1; addr = 32'h100; erdy = 1'b1; rvld = 1'b1; rdata = 32'h11112222;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (vld && erdy) hs++;
      if (ack) acks++;
    end
    n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL held_handshakes got %0d want 1", hs); end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL held_acks got %0d want 1", acks); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL held_busy got %h want 1", busy); end
    n_cmp++; if (cnt !== 32'd2) begin n_bad++; $display("FAIL held_cnt got %h want 2", cnt); end
    req = 1'b0; rvld = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL held_release_busy got %h want 0", busy); end
  endtask

  task automatic test_backpressure;
    int unstable = 0, early = 0;
    req = 1'b1; addr = 32'h80; erdy = 1'b0; rvld = 1'b0;
    tick();
    addr = 32'hFFFF;
    for (int i = 0; i < 7; i++) begin
      if (vld !== 1'b1 || eaddr !== 32'h80) unstable++;
      if (ack) early++;
      tick();
    end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable got %0d want 0 unstable cycles", unstable); end
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL bp_vld_held got %h want 1", vld); end
    erdy = 1'b1;
    tick();
    n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL bp_wait_vld got %h want 0", vld); end
    rvld = 1'b1; rdata = 32'h80808080;
    tick();
    n_cmp++; if (early !== 0 || ack !== 1'b1) begin n_bad++; $display("FAIL bp_ack got early=%0d ack=%h want early=0 ack=1", early, ack); end
    n_cmp++; if (data !== 32'h80808080) begin n_bad++; $display("FAIL bp_data got %h want 80808080", data); end
    n_cmp++; if (cnt !== 32'd3) begin n_bad++; $display("FAIL bp_cnt got %h want 3", cnt); end
    req = 1'b0; rvld = 1'b0;
    tick(); tick();
  endtask

  task automatic test_flush;
    rvld = 1'b1; rdata = 32'h5555;
    tick(); tick();
    n_cmp++; if (data !== 32'h80808080) begin n_bad++; $display("FAIL flush_data got %h want 80808080", data); end
    n_cmp++; if (ack !== 1'b0 || rrdy !== 1'b1) begin n_bad++; $display("FAIL flush_ack_rrdy got ack=%h rrdy=%h want 0/1", ack, rrdy); end
    rvld = 1'b0; req = 1'b1; addr = 32'h44; erdy = 1'b1;
    tick(); tick();
    rvld = 1'b1; rdata = 32'h12345678;
    tick();
    n_cmp++; if (ack !== 1'b1 || data !== 32'h12345678) begin n_bad++; $display("FAIL flush_next got ack=%h data=%h want 1/12345678", ack, data); end
    req = 1'b0; rvld = 1'b0;
    tick(); tick();
  endtask

`ifdef LOGIC_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    int waited = 0;
    req = 1'b1; addr = 32'hC0; erdy = 1'b1; rvld = 1'b0;
    while (!ack && waited < 40) begin
      tick();
      waited++;
    end
    n_cmp++; if (waited !== 17) begin n_bad++; $display("FAIL timeout_latency got %0d want 17", waited); end
    n_cmp++; if (data !== 32'hDEAD0001) begin n_bad++; $display("FAIL timeout_data got %h want dead0001", data); end
    n_cmp++; if (terr !== 1'b1) begin n_bad++; $display("FAIL timeout_terr got %h want 1", terr); end
    req = 1'b0; rvld = 1'b1; rdata = 32'h5555;
    tick(); tick(); tick();
    n_cmp++; if (data !== 32'hDEAD0001 || terr !== 1'b1) begin n_bad++; $display("FAIL timeout_late got data=%h terr=%h want dead0001/1", data, terr); end
    rvld = 1'b0; req = 1'b1; addr = 32'hC4;
    tick(); tick();
    rvld = 1'b1; rdata = 32'h600DF00D;
    tick();
    n_cmp++; if (ack !== 1'b1 || data !== 32'h600DF00D) begin n_bad++; $display("FAIL timeout_next got ack=%h data=%h want 1/600df00d", ack, data); end
    n_cmp++; if (terr !== 1'b0) begin n_bad++; $display("FAIL timeout_next_terr got %h want 0", terr); end
    req = 1'b0; rvld = 1'b0;
    tick(); tick();
  endtask
`endif

  task automatic test_reset_mid;
    req = 1'b1; addr = 32'h99; erdy = 1'b1; rvld = 1'b0;
    tick(); tick();
    n_cmp++; if (rrdy !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rmid_wait got rrdy=%h busy=%h want 1/1", rrdy, busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ack, vld, rrdy, busy, terr} !== 5'b0) begin n_bad++; $display("FAIL rmid_ctrl got %b want 00000", {ack, vld, rrdy, busy, terr}); end
    n_cmp++; if (data !== 32'h0 || eaddr !== 32'h0 || cnt !== 32'h0) begin n_bad++; $display("FAIL rmid_regs got data=%h eaddr=%h cnt=%h want 0", data, eaddr, cnt); end
    rvld = 1'b1; rdata = 32'h77;
    tick();
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rmid_no_ack got %h want 0", ack); end
    req = 1'b0; rvld = 1'b0; rst = 1'b0;
    tick();
    n_cmp++; if (rrdy !== 1'b1 || ack !== 1'b0) begin n_bad++; $display("FAIL rmid_after got rrdy=%h ack=%h want 1/0", rrdy, ack); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.count_q = 32'hFFFFFFFF;
    #1 release dut.count_q;
    #1;
    n_cmp++; if (cnt !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_preset got %h want ffffffff", cnt); end
    @(posedge clk); #1;
    req = 1'b1; addr = 32'h10; erdy = 1'b1; rvld = 1'b1; rdata = 32'hCAFE;
    tick(); tick(); tick();
    n_cmp++; if (ack !== 1'b1 || cnt !== 32'h0) begin n_bad++; $display("FAIL wrap_cnt got ack=%h cnt=%h want 1/0", ack, cnt); end
    req = 1'b0; rvld = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_held();
    test_backpressure();
    test_flush();
`ifdef LOGIC_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
